// File: rtl/program_loader.sv
// program_loader: boot loader that assembles a little-endian byte stream into words for the core's instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum word verified against the sum of all data words.
module program_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rxData,
  input  logic             rxValid,
  output logic             rxReady,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemData,
  output logic [WIDTH-1:0] insMemAddr,
  output logic             cpuReset,
  output logic             busy,
  output logic             done,
  output logic             error
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  localparam state_t FIN = CHECK;
  logic [WIDTH-1:0] sum;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR} state_t;
  localparam state_t FIN = DONE;
`endif
  state_t state, state_n;
  logic [1:0] cnt;
  logic [WIDTH-1:0] word, word_n, n, idx;
  logic fire, last;
  assign fire = rxValid & rxReady;
  assign last = fire & (cnt == 2'd3);
  assign word_n = {rxData, word[WIDTH-1:8]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: state_n = start ? LEN : state;
      LEN: if (last) state_n = word_n > WIDTH'(DEPTH) ? ERROR : word_n == '0 ? FIN : DATA;
      DATA: if (last) state_n = WRITE;
      WRITE: state_n = idx == n - WIDTH'(1) ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (last) state_n = word_n == sum ? DONE : ERROR;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      word       <= '0;
      n          <= '0;
      idx        <= '0;
      rxReady    <= 1'b0;
      insMemEn   <= 1'b0;
      insMemData <= '0;
      insMemAddr <= '0;
      cpuReset   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt + 2'(fire);
      if (fire) word <= word_n;
      if (state == LEN && last) n <= word_n;
      if (state inside {IDLE, DONE, ERROR} && start) idx <= '0;
      if (state == WRITE) idx <= idx + WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
      if (state inside {IDLE, DONE, ERROR} && start) sum <= '0;
      if (state == WRITE) sum <= sum + word;
`endif
      // Outputs are decoded from the next state so they are registered yet aligned with it.
      rxReady  <= state_n inside {LEN, DATA, FIN} && state_n != DONE;
      insMemEn <= state_n == WRITE;
      if (state_n == WRITE) begin
        insMemData <= word_n;
        insMemAddr <= idx;
      end
      cpuReset <= state_n != DONE;
      busy     <= !(state_n inside {IDLE, DONE, ERROR});
      done     <= state_n == DONE;
      error    <= state_n == ERROR;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; stimulus queues expected writes, a negedge monitor checks every insMemEn pulse.
module tb_program_loader;
  logic clock = 0, reset = 1, start = 0, rxValid = 0;
  logic [7:0] rxData = 0;
  logic rxReady, insMemEn, cpuReset, busy, done, error;
  logic [31:0] insMemData, insMemAddr;
  logic [63:0] exp_q[$];
  int compared = 0, mismatched = 0;

  program_loader dut (
    .clock(clock), .reset(reset), .start(start), .rxData(rxData), .rxValid(rxValid),
    .rxReady(rxReady), .insMemEn(insMemEn), .insMemData(insMemData), .insMemAddr(insMemAddr),
    .cpuReset(cpuReset), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe; the source must be stalled during WRITE.
  always @(negedge clock) begin
    if (insMemEn) begin
      if (exp_q.size() == 0) chk("unexpected_write", {insMemAddr, insMemData}, 64'h0);
      else chk("write", {insMemAddr, insMemData}, exp_q.pop_front());
      chk("ready_in_write", rxReady, 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      rxValid = 0;
      repeat (gap) @(posedge clock);
      #1;
    end
    rxData = b;
    rxValid = 1;
    @(negedge clock);
    while (!rxReady && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!rxReady) chk("rx_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int rnd);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clock);
    #1;
    start = 0;
  endtask

  task automatic end_stream();
    rxValid = 0;
  endtask

  task automatic wait_end(input string name, input logic exp_done);
    for (int i = 0; i < 40 && !(done || error); i++) @(negedge clock);
    chk({name, "_finished"}, done | error, 1);
    chk({name, "_done"}, done, exp_done);
    chk({name, "_error"}, error, !exp_done);
    chk({name, "_cpu_reset"}, cpuReset, !exp_done);
    chk({name, "_ready"}, rxReady, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic load(input logic [31:0] words[$], input int rnd, input logic [31:0] csum);
    pulse_start();
    send_word(words.size(), rnd);
    foreach (words[i]) begin
      exp_q.push_back({32'(i), words[i]});
      send_word(words[i], rnd);
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(csum, rnd);
`else
    if (csum == 32'hFFFF_FFFF) $display("unused checksum marker");
`endif
    end_stream();
  endtask

  initial begin
    logic [31:0] w[$];
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", rxReady, 0);
    chk("rst_en", insMemEn, 0);
    chk("rst_data", insMemData, 0);
    chk("rst_addr", insMemAddr, 0);
    chk("rst_cpu_reset", cpuReset, 1);
    chk("rst_status", {busy, done, error}, 0);
    reset = 0;
    @(posedge clock);
    #1;

    // Basic load with start timing and write latency
    pulse_start();
    chk("start_ready", rxReady, 1);
    chk("start_busy", busy, 1);
    send_word(2, 0);
    exp_q.push_back({32'd0, 32'h0000_0013});
    send_word(32'h0000_0013, 0);
    chk("write_latency_en", insMemEn, 1);
    chk("write_latency_addr", insMemAddr, 0);
    exp_q.push_back({32'd1, 32'h0010_0093});
    send_word(32'h0010_0093, 0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0010_00A6, 0);
`endif
    end_stream();
    wait_end("basic", 1);

    w = {};
    load(w, 0, 32'h0);
    wait_end("empty", 1);

    // Oversize image then a good reload from ERROR
    pulse_start();
    send_word(513, 0);
    end_stream();
    wait_end("oversize", 0);
    w = {32'hDEAD_BEEF};
    load(w, 0, 32'hDEAD_BEEF);
    wait_end("after_error", 1);

    w = {32'h1111_2222, 32'h8000_0001, 32'hFFFF_FFFF};
    load(w, 0, 32'h9111_2222);
    wait_end("bp_continuous", 1);
    load(w, 1, 32'h9111_2222);
    wait_end("bp_gaps", 1);

    // Reset after two bytes of word 3; no write to address 3 may follow
    pulse_start();
    send_word(5, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'(i), 32'hA0 + 32'(i)});
      send_word(32'hA0 + 32'(i), 0);
    end
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1;
    rxValid = 0;
    @(posedge clock);
    #1;
    chk("midrst_ready", rxReady, 0);
    chk("midrst_en", insMemEn, 0);
    chk("midrst_addr", insMemAddr, 0);
    chk("midrst_cpu_reset", cpuReset, 1);
    chk("midrst_status", {busy, done, error}, 0);
    reset = 0;
    repeat (5) @(posedge clock);
    #1;
    chk("midrst_idle", {busy, done, error}, 0);
    w = {32'h0000_0513};
    load(w, 1, 32'h0000_0513);
    wait_end("reload", 1);

    w = {32'h1234_5678};
    load(w, 0, 32'h1234_5679);
`ifdef LOADER_CHECKSUM_EN
    wait_end("checksum_bad", 0);
`else
    wait_end("no_checksum", 1);
`endif

    repeat (3) @(posedge clock);
    chk("pending_writes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the single-cycle RV32 core. It accepts a little-endian byte stream (from a UART receiver or testbench) over a valid/ready handshake and assembles 32-bit instruction words. It writes each word into the core's instruction memory through the core's `insMemEn`/`insMemData`/`insMemAddr` load port, and holds the core in reset until the image is fully loaded.

## Interface
Parameters:
- `WIDTH`, 32: data/address width; must match the core.
- `DEPTH`, 512: instruction memory capacity in words; larger images are rejected.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- `rxData`  in  8  stream byte.
- `rxValid`  in  1  `rxData` valid.
- `rxReady`  out  1  loader can accept a byte this cycle.
- `insMemEn`  out  1  instruction memory write strobe; connects to the core's `insMemEn`.
- `insMemData`  out  WIDTH  word to write.
- `insMemAddr`  out  WIDTH  word index; the core uses bits [8:0].
- `cpuReset`  out  1  reset for the core; ORed with the system reset at the core.
- `busy`  out  1  load in progress.
- `done`  out  1  image loaded; the core is running.
- `error`  out  1  load rejected.

## Operation
- Stream format, all fields little-endian:
  - 4-byte word count N.
  - N data words, 4 bytes each.
  - Checksum word, only when `LOADER_CHECKSUM_EN` is defined.
- A byte transfers on any cycle where `rxValid & rxReady` is high.
- States:
  - IDLE → LEN on `start`.
  - LEN: after the 4th byte, N > DEPTH goes to ERROR; N == 0 goes to CHECK (macro defined) or DONE; otherwise goes to DATA.
  - DATA: a 2-bit byte counter shifts bytes into the assembly register, byte 0 at bits [7:0]. The 4th byte goes to WRITE.
  - WRITE: lasts one cycle. `insMemEn`=1, `insMemData` = assembled word, `insMemAddr` = word index. Then the word index increments; the state returns to DATA, or after word N-1 goes to CHECK or DONE.
  - CHECK: receives 4 bytes, then compares them to the running sum. Equal goes to DONE; unequal goes to ERROR.
  - DONE and ERROR: `start` → LEN, restarting with the word index and sum cleared.
- `rxReady` = 1 in LEN, DATA and CHECK only; it is 0 in IDLE, WRITE, DONE and ERROR.
- `start` is ignored in LEN, DATA, WRITE and CHECK.
- `cpuReset` = 1 in every state except DONE.
- `busy` = 1 in LEN, DATA, WRITE and CHECK.
- `done` = 1 only in DONE; `error` = 1 only in ERROR.
- Word index and N are 32-bit; the word index is zero-extended onto `insMemAddr`.
- Checksum is the sum of all N data words modulo 2^32.
- Bytes arriving with `rxReady` = 0 are not consumed; the source holds them.

## Timing
- All outputs are registered. Reset values: `rxReady` 0, `insMemEn` 0, `insMemData` 0, `insMemAddr` 0, `cpuReset` 1, `busy` 0, `done` 0, `error` 0; state is IDLE.
- `start` at edge k: LEN is entered and `rxReady`=1 from cycle k+1.
- Write latency: the 4th byte of word i is accepted at edge k. In cycle k+1, `insMemEn`=1 with addr i. `rxReady` is back to 1 at cycle k+2.
- Peak throughput: one word per 5 cycles.
- After the final WRITE, or after the last CHECK byte, `cpuReset` falls on the next edge. The core fetches from pc 0 the cycle after that.
- Reset mid-load: all state returns to reset values at that edge. Any partial word is discarded and no `insMemEn` pulse follows. Words already written stay in memory.
- `start` coinciding with `reset`: reset wins.

## Configuration
- `LOADER_CHECKSUM_EN`:
  - Defined: the sum register and CHECK state are built in; the stream carries a trailing 4-byte checksum; a mismatch goes to ERROR.
  - Undefined: no sum logic and no CHECK state; the stream ends after the N data words and DONE follows the last WRITE.

## Test plan
- Basic load: reset, `start`, stream N=2 with words 0x00000013 and 0x00100093 (plus checksum 0x001000A6 if defined). Expect exactly two `insMemEn` pulses: addr 0 data 0x00000013, then addr 1 data 0x00100093. Then `done`=1 and `cpuReset`=0.
- Empty image: N=0 (plus checksum 0). Expect no `insMemEn` pulse, DONE, and `rxReady`=0 afterwards.
- Oversize: N=513. Expect ERROR after the 4th length byte, `rxReady`=0, no writes, `cpuReset`=1. Then `start` plus a valid N=1 stream reaches DONE.
- Backpressure: hold `rxValid` high continuously. Expect `rxReady`=0 in each WRITE cycle and no byte lost or duplicated. Also insert random `rxValid` gaps; expect identical written words.
- Reset mid-word: assert `reset` after 2 of the 4 bytes of word 3. Expect reset values next cycle, no write to addr 3, and a clean reload afterwards.
- Checksum (macro defined): N=1, word 0x12345678, checksum 0x12345679. Expect ERROR with `cpuReset` held at 1. With the macro undefined, the same stream without the checksum field reaches DONE.
